axilite_master: RTL
===================

Name: axilite_master

Overview:
AXI4-Lite initiator, the opposite end of the team's axilite_slave config-register block. It turns a simple single-beat command interface (firmware sequencer, test stimulus, or CPU bridge) into AXI4-Lite read/write transactions, and returns the response and read data on a response interface. One transaction is outstanding at a time. All AXI outputs are registered.

Parameters:
ADDR_W, 32, address width of cmd_addr and m_axi_awaddr/m_axi_araddr
DATA_W, 32, data width; must be 32 or 64; strobe width is DATA_W/8

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when high with cmd_valid
cmd_write  in  1  1 = write, 0 = read
cmd_addr  in  ADDR_W  byte address, passed unmodified
cmd_wdata  in  DATA_W  write data
cmd_wstrb  in  DATA_W/8  write byte strobes
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_rdata  out  DATA_W  read data; 0 for writes
rsp_resp  out  2  captured BRESP or RRESP
rsp_write  out  1  echo of cmd_write
busy  out  1  high whenever state != IDLE
m_axi_awaddr/awvalid/awready  out/out/in  ADDR_W/1/1  write address channel
m_axi_wdata/wstrb/wvalid/wready  out/out/out/in  DATA_W/DATA_W/8/1/1  write data channel
m_axi_bresp/bvalid/bready  in/in/out  2/1/1  write response channel
m_axi_araddr/arvalid/arready  out/out/in  ADDR_W/1/1  read address channel
m_axi_rdata/rresp/rvalid/rready  in/in/in/out  DATA_W/2/1/1  read data channel

Behaviour:
- Reset (async assert, sync-safe release): state IDLE; every valid/ready output 0; all address/data/resp registers 0; busy 0.
- cmd_ready = (state == IDLE); decoded from state only, no path from cmd_valid.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
- IDLE: on cmd_valid, register addr/wdata/wstrb/write.
  - Write goes to WR_ADDR_DATA with awvalid=1 and wvalid=1 next cycle.
  - Read goes to RD_ADDR with arvalid=1 next cycle.
- WR_ADDR_DATA: AW and W complete independently; each valid drops the cycle after its own handshake, tracked by aw_done/w_done flags. Same-cycle completion of both is legal. When both are done, go to WR_RESP with bready=1.
- WR_RESP: on bvalid, capture bresp, clear bready, set rsp_rdata=0, and go to RSP.
- RD_ADDR: on arready, drop arvalid, set rready=1, and go to RD_DATA.
- RD_DATA: on rvalid, capture rdata and rresp, clear rready, and go to RSP.
- RSP: rsp_valid=1 and held stable until rsp_ready, then go to IDLE. A new cmd is accepted no earlier than the cycle after the rsp handshake.
- Valids never depend combinationally on the matching ready. Once asserted, address, data and strobe are held stable until the handshake.
- Minimum latency with all readies/valids high at once: cmd accepted at cycle 0, AXI valids at cycle 1, bready/rready at cycle 2, rsp_valid at cycle 3.
- A non-OKAY response is passed through unchanged; no retry.
- Reset asserted mid-transaction: immediate return to IDLE, all valids drop, and the response is lost. This is allowed by AXI at reset.
- bvalid or rvalid arriving in an unexpected state is ignored, because bready/rready are low.

Optional Feature:
Macro AXIL_MASTER_ERR_CNT_EN.
- Defined: adds output port err_count (16 bits, reset 0). It increments, saturating at 16'hFFFF, on every captured response with resp != OKAY. It also adds input err_clr (1 bit): err_clr clears the counter to 0, and a clear wins over a simultaneous increment.
- Undefined: neither port exists and no counter logic is built.

Decomposition:
- Package axilite_pkg:
  - Response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
  - FSM state enum axil_mst_state_t.
  - Shared with axilite_slave.
- No sub-module. A single FSM plus datapath registers is the natural size.

Test Plan:
1. Write 0x10000000, data 0xDEADBEEF, strb 0xF, slave with all readies tied high: AW and W both complete at cycle 1, rsp_valid at cycle 3, rsp_resp=00, rsp_rdata=0.
2. Read 0x10000004, slave returns 0x12345678 after 5 wait cycles on arready and 3 on rvalid: arvalid is held stable for 5 cycles, rsp_rdata=0x12345678, rsp_resp=00.
3. Write where wready comes 4 cycles before awready: wvalid drops after its handshake, awvalid persists, and bready rises only after both are done.
4. Read of 0x10000010 where the slave returns RRESP=SLVERR with 0xBAD: rsp_resp=10 and rsp_rdata=0xBAD. With AXIL_MASTER_ERR_CNT_EN, err_count goes from 0 to 1; with err_clr pulsed on the same cycle, it stays 0.
5. rsp_ready held low for 10 cycles, with cmd_valid high holding a second command: cmd_ready stays 0 and rsp is stable. The second command is accepted the cycle after rsp_ready.
6. aresetn asserted while in WR_RESP: all valids and readies are 0 immediately and busy is 0. After release, a read completes normally.

Source files
------------

// File: rtl/axilite_pkg.sv
// Shared AXI4-Lite definitions for the axilite_master / axilite_slave pair:
// response codes, initiator FSM state encoding and a response classifier.
package axilite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam int ERR_CNT_W = 16;

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA,
    RSP
  } axil_mst_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/axilite_master.sv
// AXI4-Lite initiator: single-beat command in, one outstanding transaction, response out.
// Optional AXIL_MASTER_ERR_CNT_EN adds err_count/err_clr (saturating non-OKAY response counter).
module axilite_master
  import axilite_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                aclk,
  input  logic                aresetn,
`ifdef AXIL_MASTER_ERR_CNT_EN
  input  logic                err_clr,
  output logic [15:0]         err_count,
`endif
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_wdata,
  input  logic [DATA_W/8-1:0] cmd_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [1:0]          rsp_resp,
  output logic                rsp_write,
  output logic                busy,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready
);

  if (DATA_W != 32 && DATA_W != 64) begin : g_bad_data_w
    $error("axilite_master: DATA_W must be 32 or 64");
  end

  axil_mst_state_t state_q, state_d;

  logic [ADDR_W-1:0] addr_q;
  logic aw_done_q, w_done_q;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic aw_done_now, w_done_now;

  // Handshakes qualify on our own registered valid/ready, so unexpected
  // bvalid/rvalid outside their wait state are ignored naturally.
  assign aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_hs  = m_axi_wvalid  & m_axi_wready;
  assign b_hs  = m_axi_bready  & m_axi_bvalid;
  assign ar_hs = m_axi_arvalid & m_axi_arready;
  assign r_hs  = m_axi_rready  & m_axi_rvalid;

  assign aw_done_now = aw_done_q | aw_hs;
  assign w_done_now  = w_done_q  | w_hs;

  assign cmd_ready    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:         if (cmd_valid) state_d = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if (aw_done_now && w_done_now) state_d = WR_RESP;
      WR_RESP:      if (b_hs) state_d = RSP;
      RD_ADDR:      if (ar_hs) state_d = RD_DATA;
      RD_DATA:      if (r_hs) state_d = RSP;
      RSP:          if (rsp_ready) state_d = IDLE;
      default:      state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= RESP_OKAY;
      rsp_write     <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            addr_q        <= cmd_addr;
            m_axi_wdata   <= cmd_wdata;
            m_axi_wstrb   <= cmd_wstrb;
            rsp_write     <= cmd_write;
            m_axi_awvalid <= cmd_write;
            m_axi_wvalid  <= cmd_write;
            m_axi_arvalid <= ~cmd_write;
            aw_done_q     <= 1'b0;
            w_done_q      <= 1'b0;
          end
        end
        WR_ADDR_DATA: begin
          // AW and W retire independently; each valid drops after its own handshake.
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            aw_done_q     <= 1'b1;
          end
          if (w_hs) begin
            m_axi_wvalid <= 1'b0;
            w_done_q     <= 1'b1;
          end
          if (aw_done_now && w_done_now) m_axi_bready <= 1'b1;
        end
        WR_RESP: begin
          if (b_hs) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_valid    <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            m_axi_rready <= 1'b0;
            rsp_resp     <= m_axi_rresp;
            rsp_rdata    <= m_axi_rdata;
            rsp_valid    <= 1'b1;
          end
        end
        RSP: begin
          if (rsp_ready) rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef AXIL_MASTER_ERR_CNT_EN
  logic       resp_err;
  logic [1:0] cap_resp;

  assign cap_resp = (state_q == WR_RESP) ? m_axi_bresp : m_axi_rresp;
  assign resp_err = (((state_q == WR_RESP) && b_hs) || ((state_q == RD_DATA) && r_hs))
                    && resp_is_err(cap_resp);

  // Clear takes priority over a same-cycle increment; the count saturates.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                     err_count <= '0;
    else if (err_clr)                 err_count <= '0;
    else if (resp_err && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
  end
`endif

endmodule
